// File: rtl/up_down_key_pkg.sv
// up_down_key_pkg: key indices, owner FSM encoding and press-priority helper
// shared by the Up/Down game push-button front end.
`default_nettype none

package up_down_key_pkg;

  localparam int NUM_KEYS  = 3;
  localparam int KEY_NUM0  = 0;
  localparam int KEY_NUM1  = 1;
  localparam int KEY_START = 2;

  typedef logic [1:0] key_idx_t;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_HOLD     = 2'd1;
  localparam logic [1:0] ST_REPEAT   = 2'd2;
  localparam logic [1:0] ST_WAIT_REL = 2'd3;

  // Simultaneous presses resolve Start > Num1 > Num0.
  function automatic key_idx_t pick_key(input logic [NUM_KEYS-1:0] fall);
    key_idx_t idx;
    if (fall[KEY_START])     idx = key_idx_t'(KEY_START);
    else if (fall[KEY_NUM1]) idx = key_idx_t'(KEY_NUM1);
    else                     idx = key_idx_t'(KEY_NUM0);
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/up_down_key_ctrl_debounce.sv
// key_debounce: 2-flop synchroniser plus stable-level debouncer for one
// active-low button, with one-cycle falling/rising flags on accepted changes.
`default_nettype none

module key_debounce #(
  parameter int DEB_CYC = 500000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_i,
  output logic level_o,
  output logic fall_o,
  output logic rise_o
);

  localparam int CW = $clog2(DEB_CYC) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);

  logic [1:0]    sync_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fall_q, fall_d;
  logic          rise_q, rise_d;

  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    fall_d   = 1'b0;
    rise_d   = 1'b0;
    if (sync_q[1] != stable_q) begin
      // Accept only after the mismatch has held for DEB_CYC cycles.
      if (cnt_q == CNT_LAST) begin
        stable_d = sync_q[1];
        fall_d   = ~sync_q[1];
        rise_d   = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q   <= 2'b11;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      fall_q   <= 1'b0;
      rise_q   <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], key_i};
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      fall_q   <= fall_d;
      rise_q   <= rise_d;
    end
  end

  assign level_o = stable_q;
  assign fall_o  = fall_q;
  assign rise_o  = rise_q;

endmodule

`default_nettype wire

// File: rtl/up_down_key_ctrl.sv
// up_down_key_ctrl: debounces Num0/Num1/Start, arbitrates a single owner key
// and emits active-low one-clock strobes with hold-to-repeat on digit keys.
`default_nettype none

module up_down_key_ctrl
  import up_down_key_pkg::*;
#(
  parameter int DEB_CYC = 500000,
  parameter int REP_DLY = 25000000,
  parameter int REP_PER = 5000000
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       i_Key0,
  input  logic       i_Key1,
  input  logic       i_Start,
  output logic       o_fNum0,
  output logic       o_fNum1,
  output logic       o_fStart,
  output logic [2:0] o_Held
);

  localparam int RMAX = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
  localparam int RW   = $clog2(RMAX) + 1;
  localparam logic [RW-1:0] DLY_LAST = RW'(REP_DLY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REP_PER - 1);

  logic [NUM_KEYS-1:0] w_raw;
  logic [NUM_KEYS-1:0] w_level;
  logic [NUM_KEYS-1:0] w_fall;
  logic [NUM_KEYS-1:0] w_rise;

  assign w_raw = {i_Start, i_Key1, i_Key0};

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(
      .DEB_CYC (DEB_CYC)
    ) u_deb (
      .clk_i   (Clk),
      .rst_i   (Rst),
      .key_i   (w_raw[k]),
      .level_o (w_level[k]),
      .fall_o  (w_fall[k]),
      .rise_o  (w_rise[k])
    );
  end

  logic [1:0]          state_q, state_d;
  key_idx_t            owner_q, owner_d;
  logic [RW-1:0]       rcnt_q, rcnt_d;
  logic [NUM_KEYS-1:0] strobe_q, strobe_d;
  logic                w_release;

  assign w_release = w_level[owner_q] | w_rise[owner_q];

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rcnt_d   = rcnt_q;
    strobe_d = '0;
    case (state_q)
      ST_IDLE: begin
        // Only fresh falling edges are served; keys held from an earlier
        // ownership must be released and pressed again.
        if (|w_fall) begin
          owner_d  = pick_key(w_fall);
          strobe_d = 3'b001 << owner_d;
          rcnt_d   = '0;
          state_d  = (owner_d == key_idx_t'(KEY_START)) ? ST_WAIT_REL : ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (w_release) begin
          state_d = ST_IDLE;
          rcnt_d  = '0;
        end else if (rcnt_q == DLY_LAST) begin
          strobe_d = 3'b001 << owner_q;
          rcnt_d   = '0;
          state_d  = ST_REPEAT;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      ST_REPEAT: begin
        if (w_release) begin
          state_d = ST_IDLE;
          rcnt_d  = '0;
        end else if (rcnt_q == PER_LAST) begin
          strobe_d = 3'b001 << owner_q;
          rcnt_d   = '0;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      ST_WAIT_REL: begin
        if (w_release) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        rcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      rcnt_q   <= '0;
      strobe_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rcnt_q   <= rcnt_d;
      strobe_q <= strobe_d;
    end
  end

  assign o_fNum0  = ~strobe_q[KEY_NUM0];
  assign o_fNum1  = ~strobe_q[KEY_NUM1];
  assign o_fStart = ~strobe_q[KEY_START];
  assign o_Held   = ~w_level;

endmodule

`default_nettype wire

// File: tb/tb_up_down_key_ctrl.sv
// tb_up_down_key_ctrl: directed scenarios for up_down_key_ctrl with
// DEB_CYC=4, REP_DLY=20, REP_PER=8 and hand-derived strobe edges.
`default_nettype none

module tb_up_down_key_ctrl;

  logic       Clk;
  logic       Rst;
  logic       i_Key0, i_Key1, i_Start;
  logic       o_fNum0, o_fNum1, o_fStart;
  logic [2:0] o_Held;

  int checks   = 0;
  int failures = 0;

  up_down_key_ctrl #(
    .DEB_CYC (4),
    .REP_DLY (20),
    .REP_PER (8)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .i_Key0   (i_Key0),
    .i_Key1   (i_Key1),
    .i_Start  (i_Start),
    .o_fNum0  (o_fNum0),
    .o_fNum1  (o_fNum1),
    .o_fStart (o_fStart),
    .o_Held   (o_Held)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      {i_Start, i_Key1, i_Key0} = 3'($urandom_range(0, 7));
      tick();
      checks++;
      if ({o_fStart, o_fNum1, o_fNum0} !== 3'b111) begin
        failures++;
        $display("FAIL reset_strobes cycle %0d: got %b expected 111", i, {o_fStart, o_fNum1, o_fNum0});
      end
      checks++;
      if (o_Held !== 3'b000) begin
        failures++;
        $display("FAIL reset_held cycle %0d: got %b expected 000", i, o_Held);
      end
    end
    {i_Start, i_Key1, i_Key0} = 3'b111;
    tick();
    Rst = 1'b0;
    settle(12);
    checks++;
    if ({o_fStart, o_fNum1, o_fNum0, o_Held} !== 6'b111_000) begin
      failures++;
      $display("FAIL reset_idle: got %b expected 111000", {o_fStart, o_fNum1, o_fNum0, o_Held});
    end
  endtask

  task automatic test_clean_press();
    logic [2:0] exp_s, exp_h;
    i_Key0 = 1'b0;
    for (int e = 0; e <= 30; e++) begin
      tick();
      exp_s = (e == 6) ? 3'b110 : 3'b111;
      exp_h = (e >= 5 && e < 20) ? 3'b001 : 3'b000;
      checks++;
      if ({o_fStart, o_fNum1, o_fNum0} !== exp_s) begin
        failures++;
        $display("FAIL clean_press_strobe edge %0d: got %b expected %b", e, {o_fStart, o_fNum1, o_fNum0}, exp_s);
      end
      checks++;
      if (o_Held !== exp_h) begin
        failures++;
        $display("FAIL clean_press_held edge %0d: got %b expected %b", e, o_Held, exp_h);
      end
      if (e == 14) i_Key0 = 1'b1;
    end
    settle(5);
  endtask

  task automatic test_bounce();
    logic [2:0] exp_s;
    for (int e = 0; e <= 34; e++) begin
      if (e < 12) i_Key1 = ((e % 4) < 2) ? 1'b0 : 1'b1;
      else if (e <= 24) i_Key1 = 1'b0;
      else i_Key1 = 1'b1;
      // Input set here is first sampled by edge e.
      tick();
      exp_s = (e == 18) ? 3'b101 : 3'b111;
      checks++;
      if ({o_fStart, o_fNum1, o_fNum0} !== exp_s) begin
        failures++;
        $display("FAIL bounce_strobe edge %0d: got %b expected %b", e, {o_fStart, o_fNum1, o_fNum0}, exp_s);
      end
    end
    settle(5);
  endtask

  task automatic test_auto_repeat();
    logic [2:0] exp_s, exp_h;
    i_Key1 = 1'b0;
    for (int e = 0; e <= 65; e++) begin
      tick();
      exp_s = (e == 6 || e == 26 || e == 34 || e == 42 || e == 50) ? 3'b101 : 3'b111;
      exp_h = (e >= 5 && e < 55) ? 3'b010 : 3'b000;
      checks++;
      if ({o_fStart, o_fNum1, o_fNum0} !== exp_s) begin
        failures++;
        $display("FAIL repeat_strobe edge %0d: got %b expected %b", e, {o_fStart, o_fNum1, o_fNum0}, exp_s);
      end
      checks++;
      if (o_Held !== exp_h) begin
        failures++;
        $display("FAIL repeat_held edge %0d: got %b expected %b", e, o_Held, exp_h);
      end
      if (e == 49) i_Key1 = 1'b1;
    end
    settle(5);
  endtask

  task automatic test_arbitration();
    logic [2:0] exp_s, exp_h;
    i_Start = 1'b0;
    i_Key0  = 1'b0;
    for (int e = 0; e <= 25; e++) begin
      tick();
      exp_s = (e == 6) ? 3'b011 : 3'b111;
      exp_h = (e >= 5 && e < 20) ? 3'b101 : 3'b000;
      checks++;
      if ({o_fStart, o_fNum1, o_fNum0} !== exp_s) begin
        failures++;
        $display("FAIL arb_strobe edge %0d: got %b expected %b", e, {o_fStart, o_fNum1, o_fNum0}, exp_s);
      end
      checks++;
      if (o_Held !== exp_h) begin
        failures++;
        $display("FAIL arb_held edge %0d: got %b expected %b", e, o_Held, exp_h);
      end
      if (e == 14) begin
        i_Start = 1'b1;
        i_Key0  = 1'b1;
      end
    end
    settle(4);
    i_Key0 = 1'b0;
    for (int e = 0; e <= 14; e++) begin
      tick();
      exp_s = (e == 6) ? 3'b110 : 3'b111;
      checks++;
      if ({o_fStart, o_fNum1, o_fNum0} !== exp_s) begin
        failures++;
        $display("FAIL arb_repress_strobe edge %0d: got %b expected %b", e, {o_fStart, o_fNum1, o_fNum0}, exp_s);
      end
    end
    i_Key0 = 1'b1;
    settle(10);
  endtask

  task automatic test_reset_mid_hold();
    logic [2:0] exp_s, exp_h;
    i_Key1 = 1'b0;
    for (int e = 0; e <= 45; e++) begin
      tick();
      exp_s = (e == 6 || e == 26 || e == 39) ? 3'b101 : 3'b111;
      exp_h = ((e >= 5 && e <= 29) || e >= 38) ? 3'b010 : 3'b000;
      checks++;
      if ({o_fStart, o_fNum1, o_fNum0} !== exp_s) begin
        failures++;
        $display("FAIL rst_mid_strobe edge %0d: got %b expected %b", e, {o_fStart, o_fNum1, o_fNum0}, exp_s);
      end
      checks++;
      if (o_Held !== exp_h) begin
        failures++;
        $display("FAIL rst_mid_held edge %0d: got %b expected %b", e, o_Held, exp_h);
      end
      if (e == 29) Rst = 1'b1;
      if (e == 32) Rst = 1'b0;
    end
    i_Key1 = 1'b1;
    settle(10);
  endtask

  initial begin
    Rst     = 1'b1;
    i_Key0  = 1'b1;
    i_Key1  = 1'b1;
    i_Start = 1'b1;
    test_reset();
    test_clean_press();
    test_bounce();
    test_auto_repeat();
    test_arbitration();
    test_reset_mid_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/up_down_key_ctrl.md
Name: up_down_key_ctrl

Overview:
- Push-button front end for the Up/Down number game.
- Takes three raw, bouncing, active-low buttons (Num0, Num1, Start) and converts them into the clean active-low one-clock strobes the game core consumes on fNum0/fNum1/fStart.
- Performs synchronisation, debouncing, single-key arbitration and hold-to-repeat on the digit keys.
- Sits between board pins and the game core.

Parameters:
- DEB_CYC, 500000, consecutive stable cycles required to accept a level change (10 ms at 50 MHz).
- REP_DLY, 25000000, hold cycles from accepted press pulse to first auto-repeat pulse.
- REP_PER, 5000000, cycles between subsequent auto-repeat pulses.

Ports:
- Clk  input  1  system clock.
- Rst  input  1  reset, asynchronous, active-high.
- i_Key0  input  1  raw Num0 button, active-low, asynchronous.
- i_Key1  input  1  raw Num1 button, active-low, asynchronous.
- i_Start  input  1  raw Start button, active-low, asynchronous.
- o_fNum0  output  1  Num0 strobe, idle 1, low for exactly one Clk.
- o_fNum1  output  1  Num1 strobe, idle 1, low for exactly one Clk.
- o_fStart  output  1  Start strobe, idle 1, low for exactly one Clk.
- o_Held  output  3  debounced pressed state {Start,Num1,Num0}, active-high, for LEDs.

Behaviour:
- Reset (Rst=1, async):
  - o_fNum0 = o_fNum1 = o_fStart = 1; o_Held = 0.
  - Sync flops = 1, stable levels = 1, all counters = 0, FSM = IDLE.
- Sync: each raw input passes through a 2-flop synchroniser.
- Debounce (per key):
  - Counter increments while the synced level differs from the stable level; it clears on any cycle they match.
  - When the counter equals DEB_CYC-1 and the mismatch persists, the stable level takes the synced value and the counter clears.
- Latency:
  - Clean edge first sampled at edge k → stable level changes at edge k+1+DEB_CYC.
  - Strobe is registered low at edge k+2+DEB_CYC and high again at the next edge.
- Owner FSM states: IDLE, HOLD, REPEAT, WAIT_REL; owner register identifies the key being served.
  - IDLE: on a stable falling edge of any key, emit that key's strobe and make it owner.
    - Simultaneous falls resolve by priority Start > Num1 > Num0.
    - Digit owner → HOLD with repeat counter = 0; Start owner → WAIT_REL.
  - HOLD: counter runs. At REP_DLY-1, emit the owner strobe, clear the counter, go to REPEAT.
  - REPEAT: emit the owner strobe every REP_PER cycles.
  - HOLD, REPEAT and WAIT_REL: owner's stable level returning to 1 → IDLE. No further strobe that cycle; release has priority over a coincident repeat.
- Non-owner keys pressed while an owner exists:
  - Are debounced (o_Held reflects them) but never strobe.
  - After IDLE they are not served until released and re-pressed, because only falling edges are accepted.
- At most one strobe is low in any cycle.
- Reset mid-operation: everything returns to reset values immediately. A key still held when Rst deasserts is treated as a new press and produces one strobe DEB_CYC+2 edges after the first post-reset sampling edge.
- Width rules: counters are $clog2(param)+1 bits and never wrap; they saturate or clear as specified above.

Decomposition:
- Package up_down_key_pkg holds:
  - key index constants (KEY_NUM0=0, KEY_NUM1=1, KEY_START=2);
  - FSM state encoding;
  - the priority order.
- Sub-module key_debounce (sync + debounce counter + stable level + falling/rising edge flags), parameterised by DEB_CYC and instantiated three times.

Test Plan:
Directed tests override DEB_CYC=4, REP_DLY=20, REP_PER=8. Edge 0 is the first edge sampling the raw change.
1. Reset check: Rst=1 with random raw inputs → all strobes 1, o_Held=000, held for the whole reset.
2. Clean press: i_Key0 low for 15 cycles → o_fNum0 low exactly at edge 6 only; o_Held[0]=1 from edge 5 to 5 edges after release.
3. Bounce: i_Key1 toggles every 2 cycles for 12 cycles, then stays low → exactly one o_fNum1 pulse, 6 edges after the final low is sampled.
4. Auto-repeat: i_Key1 held low for 50 cycles → o_fNum1 pulses at edges 6, 26, 34, 42, 50; none at 58 (released at edge 55).
5. Arbitration: i_Start and i_Key0 fall on the same edge, held 15 cycles → only o_fStart pulses, at edge 6. i_Key0 then released and re-pressed → one o_fNum0 pulse.
6. Reset mid-hold: i_Key1 held, Rst pulsed high at edge 30 for 3 cycles, key still low → no strobe during reset; one o_fNum1 pulse 6 edges after the first post-reset edge.
